// File: rtl/mem_access_aligner.sv
// Load/store aligner: splits MEM-stage accesses into BYTES-aligned bus beats with strobes,
// lane-shifted write data and extended load results. Define MISALIGN_TRAP_EN to trap misaligned accesses.
module mem_access_aligner #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_width,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  bus_valid,
    output logic                  bus_we,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W/8-1:0]   bus_wstrb,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic                  bus_ack,
    input  logic [DATA_W-1:0]     bus_rdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);
    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);
    localparam int unsigned MW    = 2 * BYTES;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;
    state_t state, state_nxt;

    logic              we_q;
    logic [2:0]        width_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rd0_q;
    logic [DATA_W-1:0] rd1_q;
    logic              err_q;

    function automatic logic [3:0] size_of(input logic [2:0] w);
        case (w)
            3'b001:         return 4'd8;
            3'b010, 3'b101: return 4'd4;
            3'b011, 3'b110: return 4'd2;
            3'b100, 3'b111: return 4'd1;
            default:        return 4'd0;
        endcase
    endfunction

    logic [3:0] in_size;
    logic       in_err;
    assign in_size = size_of(req_width);

`ifdef MISALIGN_TRAP_EN
    logic [OFF_W-1:0] in_off;
    assign in_off = req_addr[OFF_W-1:0];
`endif

    always_comb begin
        in_err = (5'(in_size) > 5'(BYTES));
`ifdef MISALIGN_TRAP_EN
        if (in_size != 4'd0 && ((5'(in_off) & (5'(in_size) - 5'd1)) != 5'd0))
            in_err = 1'b1;
`endif
    end

    logic [3:0]          size;
    logic [OFF_W-1:0]    off;
    logic                split;
    logic [ADDR_W-1:0]   beat_addr;
    logic [MW-1:0]       mask_sh;
    logic [2*DATA_W-1:0] wdata_sh;
    logic [DATA_W-1:0]   raw;
    logic [DATA_W-1:0]   ext_mask;
    logic [DATA_W-1:0]   load_ext;
    logic                sgn;

    assign size      = size_of(width_q);
    assign off       = addr_q[OFF_W-1:0];
    assign split     = (5'(off) + 5'(size)) > 5'(BYTES);
    assign beat_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign mask_sh   = MW'((16'd1 << size) - 16'd1) << off;
    assign wdata_sh  = {{DATA_W{1'b0}}, wdata_q} << {off, 3'b000};
    assign raw       = DATA_W'({rd1_q, rd0_q} >> {off, 3'b000});

    // Bits above the access size are replaced by the sign bit (or zero); a full-width
    // shift leaves ext_mask empty so doubles pass straight through.
    always_comb begin
        ext_mask = '1 << {size, 3'b000};
        case (width_q)
            3'b010:  sgn = raw[31];
            3'b011:  sgn = raw[15];
            3'b100:  sgn = raw[7];
            default: sgn = 1'b0;
        endcase
        load_ext = (raw & ~ext_mask) | (sgn ? ext_mask : '0);
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        bus_valid = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_wstrb = '0;
        bus_wdata = '0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_nxt = (in_err || in_size == 4'd0) ? RESP : BEAT0;
            end
            BEAT0: begin
                bus_valid = 1'b1;
                bus_we    = we_q;
                bus_addr  = beat_addr;
                bus_wstrb = mask_sh[BYTES-1:0];
                bus_wdata = wdata_sh[DATA_W-1:0];
                if (bus_ack)
                    state_nxt = split ? BEAT1 : RESP;
            end
            BEAT1: begin
                bus_valid = 1'b1;
                bus_we    = we_q;
                bus_addr  = beat_addr + ADDR_W'(BYTES);
                bus_wstrb = mask_sh[MW-1:BYTES];
                bus_wdata = wdata_sh[2*DATA_W-1:DATA_W];
                if (bus_ack)
                    state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                if (!we_q && !err_q)
                    rsp_rdata = load_ext;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            width_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                we_q    <= req_we;
                width_q <= req_width;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                err_q   <= in_err;
                rd0_q   <= '0;
                rd1_q   <= '0;
            end
            if (state == BEAT0 && bus_ack)
                rd0_q <= bus_rdata;
            if (state == BEAT1 && bus_ack)
                rd1_q <= bus_rdata;
        end
    end
endmodule

// File: tb/tb_mem_access_aligner.sv
// Self-checking bench for mem_access_aligner: directed plan cases plus randomized accesses
// checked against a byte-level reference model.
`timescale 1ns/1ps
module tb_mem_access_aligner;
    localparam int unsigned DW = 64;
    localparam int unsigned AW = 64;
    localparam int unsigned NB = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [2:0]    req_width = 3'b000;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          bus_valid;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [NB-1:0] bus_wstrb;
    logic [DW-1:0] bus_wdata;
    logic          bus_ack = 1'b0;
    logic [DW-1:0] bus_rdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    int compared = 0;
    int mismatched = 0;
    logic [DW-1:0] last_rdata;
    logic          last_err;

    always #5 clk = ~clk;

    mem_access_aligner #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_width(req_width), .req_addr(req_addr), .req_wdata(req_wdata),
        .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    function automatic int size_of(input logic [2:0] w);
        case (w)
            3'd1:       return 8;
            3'd2, 3'd5: return 4;
            3'd3, 3'd6: return 2;
            3'd4, 3'd7: return 1;
            default:    return 0;
        endcase
    endfunction

    // One access: the model places each byte k at absolute address a+k, i.e. beat (off+k)/NB, lane (off+k)%NB.
    task automatic do_access(input logic we, input logic [2:0] w, input logic [AW-1:0] a,
                             input logic [DW-1:0] wd, input logic [DW-1:0] r0, input logic [DW-1:0] r1,
                             input int wt0, input int wt1, input string tag);
        int sz, off, nbeats, lat, cyc, beat, waited;
        logic err, done;
        logic [AW-1:0] exp_addr [2];
        logic [NB-1:0] exp_strb [2];
        logic [DW-1:0] exp_wdata [2];
        logic [DW-1:0] rdv [2];
        int wts [2];
        logic [DW-1:0] exp_rdata, lane_mask;

        sz  = size_of(w);
        off = int'(a % NB);
        err = (sz > NB);
`ifdef MISALIGN_TRAP_EN
        if (sz != 0 && off % sz != 0) err = 1'b1;
`endif
        nbeats = (err || sz == 0) ? 0 : (off + sz - 1) / NB + 1;
        rdv[0] = r0; rdv[1] = r1; wts[0] = wt0; wts[1] = wt1;
        for (int b = 0; b < 2; b++) begin
            exp_addr[b]  = (a - AW'(off)) + AW'(b * NB);
            exp_strb[b]  = '0;
            exp_wdata[b] = '0;
        end
        exp_rdata = '0;
        for (int k = 0; k < sz; k++) begin
            int p, b, l;
            p = off + k; b = p / NB; l = p % NB;
            exp_strb[b][l] = 1'b1;
            exp_wdata[b][8*l +: 8] = wd[8*k +: 8];
            exp_rdata[8*k +: 8] = rdv[b][8*l +: 8];
        end
        if ((w == 3'd2 || w == 3'd3 || w == 3'd4) && exp_rdata[8*sz-1])
            for (int k = 8 * sz; k < DW; k++) exp_rdata[k] = 1'b1;
        if (we || err || sz == 0) exp_rdata = '0;
        lat = 1;
        for (int b = 0; b < nbeats; b++) lat += 1 + wts[b];

        @(negedge clk);
        compared++;
        if (req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL %s req_ready_idle: got %b want 1", tag, req_ready);
        end
        req_valid = 1'b1; req_we = we; req_width = w; req_addr = a; req_wdata = wd; bus_ack = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = {$urandom(), $urandom()};
        req_wdata = {$urandom(), $urandom()};
        req_width = 3'($urandom_range(0, 7));

        cyc = 0; beat = 0; waited = 0; done = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            compared++;
            if (req_ready !== 1'b0) begin
                mismatched++;
                $display("FAIL %s req_ready_busy: got %b want 0 (cycle %0d)", tag, req_ready, cyc);
            end
            if (rsp_valid === 1'b1) begin
                done = 1'b1;
                last_rdata = rsp_rdata;
                last_err = rsp_err;
                compared++;
                if (cyc != lat) begin
                    mismatched++;
                    $display("FAIL %s latency: got %0d want %0d", tag, cyc, lat);
                end
                compared++;
                if (beat != nbeats) begin
                    mismatched++;
                    $display("FAIL %s beats: got %0d want %0d", tag, beat, nbeats);
                end
                compared++;
                if (rsp_rdata !== exp_rdata) begin
                    mismatched++;
                    $display("FAIL %s rsp_rdata: got %h want %h", tag, rsp_rdata, exp_rdata);
                end
                compared++;
                if (rsp_err !== err) begin
                    mismatched++;
                    $display("FAIL %s rsp_err: got %b want %b", tag, rsp_err, err);
                end
                compared++;
                if (bus_valid !== 1'b0) begin
                    mismatched++;
                    $display("FAIL %s bus_valid_in_resp: got %b want 0", tag, bus_valid);
                end
                bus_ack = 1'($urandom_range(0, 1));
                bus_rdata = {$urandom(), $urandom()};
            end else if (bus_valid === 1'b1) begin
                compared++;
                if (beat >= nbeats) begin
                    mismatched++;
                    $display("FAIL %s extra_beat: got beat %0d want %0d beats", tag, beat, nbeats);
                    bus_ack = 1'b1;
                    beat++;
                end else begin
                    for (int l = 0; l < NB; l++) lane_mask[8*l +: 8] = {8{exp_strb[beat][l]}};
                    if (bus_we !== we || bus_addr !== exp_addr[beat] || bus_wstrb !== exp_strb[beat] ||
                        (we && ((bus_wdata & lane_mask) !== exp_wdata[beat]))) begin
                        mismatched++;
                        $display("FAIL %s beat%0d: got we=%b addr=%h strb=%h wdata=%h want we=%b addr=%h strb=%h wdata=%h",
                                 tag, beat, bus_we, bus_addr, bus_wstrb, bus_wdata & lane_mask,
                                 we, exp_addr[beat], exp_strb[beat], exp_wdata[beat]);
                    end
                    if (waited < wts[beat]) begin
                        bus_ack = 1'b0;
                        bus_rdata = {$urandom(), $urandom()};
                        waited++;
                    end else begin
                        bus_ack = 1'b1;
                        bus_rdata = rdv[beat];
                        beat++;
                        waited = 0;
                    end
                end
            end else begin
                compared++;
                mismatched++;
                $display("FAIL %s idle_while_busy: got no bus_valid/rsp_valid want activity (cycle %0d)", tag, cyc);
            end
        end
        if (!done) begin
            compared++;
            mismatched++;
            $display("FAIL %s timeout: got no rsp_valid want one within 40 cycles", tag);
        end
        @(negedge clk);
        compared++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL %s post_resp: got rsp_valid=%b req_ready=%b want 0/1", tag, rsp_valid, req_ready);
        end
        bus_ack = 1'($urandom_range(0, 1));
    endtask

    task automatic test_reset();
        @(negedge clk);
        compared++;
        if (req_ready !== 1'b1 || bus_valid !== 1'b0 || bus_we !== 1'b0 || bus_addr !== '0 ||
            bus_wstrb !== '0 || bus_wdata !== '0 || rsp_valid !== 1'b0 || rsp_rdata !== '0 || rsp_err !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_values: got ready=%b bv=%b we=%b addr=%h strb=%h wd=%h rv=%b rd=%h err=%b want ready=1 rest 0",
                     req_ready, bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata, rsp_valid, rsp_rdata, rsp_err);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_load_byte();
        do_access(1'b0, 3'd4, 64'h1003, '0, 64'h0000_0000_8000_0000, 64'h0, 0, 0, "lb");
        compared++;
        if (last_rdata !== 64'hFFFF_FFFF_FFFF_FF80) begin
            mismatched++;
            $display("FAIL lb_value: got %h want ffffffffffffff80", last_rdata);
        end
        do_access(1'b0, 3'd7, 64'h1003, '0, 64'h0000_0000_8000_0000, 64'h0, 0, 0, "lbu");
        compared++;
        if (last_rdata !== 64'h80) begin
            mismatched++;
            $display("FAIL lbu_value: got %h want 80", last_rdata);
        end
    endtask

    task automatic test_store_word();
        do_access(1'b1, 3'd2, 64'h2006, 64'hAABB_CCDD, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 0, 0, "sw_split");
        do_access(1'b1, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, '0, '0, 1, 0, "sh_wrap");
    endtask

    task automatic test_load_double_split();
        do_access(1'b0, 3'd1, 64'h7, '0, 64'h1100_0000_0000_0000, 64'h0022_3344_5566_7788, 0, 0, "ld_split");
        compared++;
        if (last_rdata !== 64'h2233_4455_6677_8811) begin
            mismatched++;
            $display("FAIL ld_split_value: got %h want 2233445566778811", last_rdata);
        end
    endtask

    task automatic test_ack_wait_and_none();
        do_access(1'b0, 3'd2, 64'h3004, '0, 64'h8765_4321_0000_0000, '0, 4, 0, "lw_wait");
        do_access(1'b1, 3'd1, 64'h4005, {$urandom(), $urandom()}, '0, '0, 2, 3, "sd_wait_split");
        do_access(1'b0, 3'd0, 64'h5000, '0, {$urandom(), $urandom()}, '0, 0, 0, "none_ld");
        do_access(1'b1, 3'd0, 64'h5001, 64'hFFFF, '0, '0, 0, 0, "none_st");
    endtask

    task automatic test_reset_mid_beat();
        int seen;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_width = 3'd1; req_addr = 64'h7;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 64'h1;
        @(negedge clk);
        bus_ack = 1'b0;
        compared++;
        if (bus_valid !== 1'b1 || bus_addr !== 64'h8) begin
            mismatched++;
            $display("FAIL rst_mid_beat1: got bv=%b addr=%h want 1/8", bus_valid, bus_addr);
        end
        #1 rst_n = 1'b0;
        #1;
        compared++;
        if (bus_valid !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_mid_immediate: got bv=%b ready=%b rv=%b want 0/1/0", bus_valid, req_ready, rsp_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || bus_valid !== 1'b0) seen++;
        end
        compared++;
        if (seen != 0) begin
            mismatched++;
            $display("FAIL rst_mid_no_rsp: got %0d active cycles want 0", seen);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            logic [AW-1:0] a;
            a = {$urandom(), $urandom()};
            if (i % 4 == 0) a = AW'($urandom_range(0, 63));
            do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a,
                      {$urandom(), $urandom()}, {$urandom(), $urandom()}, {$urandom(), $urandom()},
                      $urandom_range(0, 2), $urandom_range(0, 2), "rand");
        end
    endtask

`ifdef MISALIGN_TRAP_EN
    task automatic test_misalign_trap();
        do_access(1'b0, 3'd3, 64'h1001, '0, 64'hFFFF_FFFF, '0, 0, 0, "trap_half");
        compared++;
        if (last_err !== 1'b1 || last_rdata !== '0) begin
            mismatched++;
            $display("FAIL trap_half_err: got err=%b rdata=%h want 1/0", last_err, last_rdata);
        end
        do_access(1'b0, 3'd3, 64'h1002, '0, 64'h0000_0000_8001_0000, '0, 0, 0, "aligned_half");
        compared++;
        if (last_err !== 1'b0 || last_rdata !== 64'hFFFF_FFFF_FFFF_8001) begin
            mismatched++;
            $display("FAIL aligned_half: got err=%b rdata=%h want 0/ffffffffffff8001", last_err, last_rdata);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_byte();
        test_store_word();
        test_load_double_split();
        test_ack_wait_and_none();
        test_reset_mid_beat();
`ifdef MISALIGN_TRAP_EN
        test_misalign_trap();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mem_access_aligner.md
Name: mem_access_aligner

Overview:
- Sequential successor to the combinational byte-mask generator in the load/store path.
- Accepts one load or store per handshake from the MEM stage and generates byte strobes and shifted write data for a DATA_W-wide data bus.
- Accesses that cross a DATA_W/8-byte boundary are split into two bus beats; read beats are merged, shifted and sign/zero-extended.
- Sits between the MEM stage and the data-memory/bus interface; one access outstanding at a time.

Parameters:
DATA_W, 64, bus/register width; legal values 32 or 64.
ADDR_W, 64, byte address width.
BYTES, DATA_W/8, derived; strobe width.
OFF_W, log2(BYTES), derived; width of the offset field addr[OFF_W-1:0].

Ports:
clk  in  1  clock; all logic on rising edge.
rst_n  in  1  reset, asynchronous assert, active-low.
req_valid  in  1  access request.
req_ready  out  1  high only in IDLE.
req_we  in  1  1 = store, 0 = load.
req_width  in  3  000 none, 001 double, 010 word, 011 half, 100 byte, 101 unsigned word, 110 unsigned half, 111 unsigned byte.
req_addr  in  ADDR_W  byte address.
req_wdata  in  DATA_W  store data, LSB-aligned.
bus_valid  out  1  bus beat request.
bus_we  out  1  beat is a write.
bus_addr  out  ADDR_W  BYTES-aligned beat address.
bus_wstrb  out  BYTES  byte enables.
bus_wdata  out  DATA_W  lane-shifted write data.
bus_ack  in  1  beat complete; bus_rdata valid for loads.
bus_rdata  in  DATA_W  read data.
rsp_valid  out  1  one-cycle completion pulse.
rsp_rdata  out  DATA_W  extended load result; 0 for stores and none.
rsp_err  out  1  access error, qualified by rsp_valid.

Behaviour:
- Reset values: all outputs 0 except req_ready = 1; state = IDLE. Reset mid-beat abandons the access with no response.
- Size: none = 0, double = 8, word/uword = 4, half/uhalf = 2, byte/ubyte = 1.
- Size mask: (1<<size)-1. Split = off+size > BYTES.
- IDLE: on req_valid and req_ready, latch the request into internal registers.
  - none: go to RESP; no bus beat.
  - double with DATA_W = 32: go to RESP with rsp_err = 1.
  - All other accesses: go to BEAT0.
- BEAT0: bus_valid = 1.
  - bus_addr = addr with low OFF_W bits cleared.
  - bus_wstrb = low BYTES bits of (mask << off).
  - bus_wdata = low DATA_W bits of (wdata << 8*off).
  - On bus_ack: capture bus_rdata into rd0; go to BEAT1 if split, else RESP.
- BEAT1: bus_addr = beat0 address + BYTES, wrapping modulo 2^ADDR_W.
  - bus_wstrb = bits [2*BYTES-1:BYTES] of (mask << off).
  - bus_wdata = high half of the 2*DATA_W shift.
  - On bus_ack: capture rd1; go to RESP.
- Bus outputs hold stable while bus_valid = 1 and bus_ack = 0.
- bus_ack received while bus_valid = 0 is ignored.
- RESP: rsp_valid = 1 for exactly one cycle, then IDLE; req_ready returns the following cycle.
  - Loads: take ({rd1, rd0} >> 8*off), truncate to size.
  - Extension: sign-extend for signed codes, zero-extend for unsigned codes; double passes through.
  - Non-split accesses use rd1 = 0.
- Latency:
  - Non-split, ack on the first bus_valid cycle: rsp_valid 2 cycles after acceptance.
  - Split: 3 cycles.
  - Each ack-wait cycle adds 1.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Misalignment is off mod size != 0 (none excluded).
  - A misaligned access issues no bus beats and goes IDLE -> RESP with rsp_err = 1 and rsp_rdata = 0.
  - BEAT1 is unreachable.
- Undefined: misaligned accesses are split or served in a single beat as described above; rsp_err only for double with DATA_W = 32.

Test Plan:
- Load byte, DATA_W = 64:
  - Stimulus: addr 0x1003, rdata 0x0000_0000_8000_0000 on ack.
  - Required: strobe 0x08, bus_addr 0x1000, rsp_rdata 0xFFFF_FFFF_FFFF_FF80.
  - Same access as unsigned byte: rsp_rdata 0x80.
- Store word:
  - Stimulus: addr 0x2006, wdata 0xAABBCCDD.
  - Required, beat0: addr 0x2000, strobe 0xC0, wdata[63:48] = 0xCCDD.
  - Required, beat1: addr 0x2008, strobe 0x03, wdata[15:0] = 0xAABB.
  - Required: rsp_valid 3 cycles after acceptance with zero-wait acks.
- Load double, split:
  - Stimulus: addr 0x7, rd0 = 0x1100_0000_0000_0000, rd1 = 0x0022_3344_5566_7788.
  - Required: rsp_rdata 0x2233_4455_6677_8811.
- Ack wait and none:
  - Stimulus: hold bus_ack low 4 cycles in BEAT0.
  - Required: bus outputs stable, req_ready low throughout.
  - Stimulus: width none.
  - Required: no bus_valid, rsp_valid on the next cycle.
- Reset mid-beat:
  - Stimulus: rst_n low in BEAT1.
  - Required: bus_valid 0 and req_ready 1 immediately; no rsp_valid after release.
- MISALIGN_TRAP_EN defined:
  - Stimulus: half access at 0x1001.
  - Required: rsp_err = 1, zero bus beats; an aligned half at 0x1002 still completes normally.
